// File: rtl/ysyx_25030081_rf_scoreboard_if.sv
// Decode/issue and write-back connection to the register file scoreboard.
// The master drives addresses, write-back and issue; the slave returns data, busy and ready.
interface ysyx_25030081_rf_scoreboard_if #(
    parameter int RF_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NR_RD         = 2
);
    logic [NR_RD*RF_ADDR_WIDTH-1:0] raddr;
    logic [NR_RD*DATA_WIDTH-1:0]    rdata;
    logic [NR_RD-1:0]               rbusy;
    logic                           wen;
    logic [RF_ADDR_WIDTH-1:0]       waddr;
    logic [DATA_WIDTH-1:0]          wdata;
    logic                           iss_valid;
    logic [RF_ADDR_WIDTH-1:0]       iss_rd;
    logic                           iss_ready;
    logic                           flush;

    modport master (
        output raddr, wen, waddr, wdata, iss_valid, iss_rd, flush,
        input  rdata, rbusy, iss_ready
    );

    modport slave (
        input  raddr, wen, waddr, wdata, iss_valid, iss_rd, flush,
        output rdata, rbusy, iss_ready
    );
endinterface

// File: rtl/ysyx_25030081_rf_scoreboard.sv
// Integer register file with combinational read ports, one write-back port,
// optional write-to-read bypass and a per-register pending-write counter.
module ysyx_25030081_rf_scoreboard #(
    parameter int RF_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NR_RD         = 2,
    parameter int CNT_WIDTH     = 2,
    parameter int BYPASS        = 1
) (
    input  logic clk,
    input  logic rst_n,
    ysyx_25030081_rf_scoreboard_if.slave bus
);
    localparam int DEPTH = 1 << RF_ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [DATA_WIDTH-1:0] rf  [DEPTH];
    logic [CNT_WIDTH-1:0]  cnt [DEPTH];

    logic wr_ok;
    logic fire;
    logic dec_en;
    logic same_reg;
    logic inc_do;
    logic dec_do;

    assign wr_ok    = bus.wen && (bus.waddr != '0);
    assign bus.iss_ready = rst_n && !bus.flush &&
                           ((bus.iss_rd == '0) || (cnt[bus.iss_rd] != CNT_MAX));
    assign fire     = bus.iss_valid && bus.iss_ready && (bus.iss_rd != '0);
    assign dec_en   = wr_ok && (cnt[bus.waddr] != '0);
    assign same_reg = (bus.iss_rd == bus.waddr);
    // An issue and a completing write to the same register cancel out.
    assign inc_do   = fire && !(dec_en && same_reg);
    assign dec_do   = dec_en && !(fire && same_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf  <= '{default: '0};
            cnt <= '{default: '0};
        end else begin
            if (wr_ok) begin
                rf[bus.waddr] <= bus.wdata;
            end
            if (bus.flush) begin
                cnt <= '{default: '0};
            end else begin
                if (inc_do) begin
                    cnt[bus.iss_rd] <= cnt[bus.iss_rd] + CNT_WIDTH'(1);
                end
                if (dec_do) begin
                    cnt[bus.waddr] <= cnt[bus.waddr] - CNT_WIDTH'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NR_RD; g++) begin : g_rd
        logic [RF_ADDR_WIDTH-1:0] addr;
        logic                     hit;

        assign addr = bus.raddr[g*RF_ADDR_WIDTH +: RF_ADDR_WIDTH];
        // Register 0 is never written and never counted, so it reads 0 and idle.
        assign hit  = (BYPASS != 0) && wr_ok && (bus.waddr == addr);

        assign bus.rdata[g*DATA_WIDTH +: DATA_WIDTH] =
            !rst_n ? '0 : (hit ? bus.wdata : rf[addr]);
        assign bus.rbusy[g] = rst_n && (cnt[addr] != '0) &&
                              !(hit && (cnt[addr] == CNT_WIDTH'(1)));
    end
endmodule
